rs_multi_dispatch: RTL

//  Parametrised reservation station between the dispatcher and the edge-PE array.

---
 rtl/rs_pkg.sv | 23 ++
 rtl/rs_rank_select.sv | 42 ++++
 rtl/rs_multi_dispatch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared types and defaults for the reservation station and its neighbours
// (dispatcher, edge-PE array).
package rs_pkg;

  localparam int RS_DEPTH      = 8;
  localparam int RS_NUM_PE     = 4;
  localparam int RS_PKT_W      = 30;
  localparam int RS_ITER_W     = 3;
  localparam int RS_ITER_LSB   = 7;
  localparam int RS_STARVE_LIM = 15;
  localparam int RS_WAIT_W     = $clog2(RS_STARVE_LIM + 1);

  typedef struct packed {
    logic                 valid;
    logic [RS_PKT_W-1:0]  packet;
    logic [RS_WAIT_W-1:0] wait_cnt;
  } rs_entry_t;

  function automatic logic [RS_ITER_W-1:0] iter_mask(input logic [RS_PKT_W-1:0] packet);
    return packet[RS_ITER_LSB +: RS_ITER_W];
  endfunction

endpackage

// File: rtl/rs_rank_select.sv
// Cascaded max-pickers: stage k grants the best remaining entry by
// {key, age}, excluding everything granted by stages 0..k-1.
module rs_rank_select #(
  parameter int DEPTH  = 8,
  parameter int NUM_PE = 4
) (
  input  logic [DEPTH-1:0]             cand,
  input  logic [DEPTH-1:0][1:0]        key,
  input  logic [DEPTH-1:0][DEPTH-1:0]  older,
  output logic [NUM_PE-1:0][DEPTH-1:0] grant,
  output logic [NUM_PE-1:0]            grant_valid
);

  for (genvar gk = 0; gk < NUM_PE; gk++) begin : g_pick
    logic [DEPTH-1:0] pool;
    logic [DEPTH-1:0] win;

    if (gk == 0) begin : g_first
      assign pool = cand;
    end else begin : g_rest
      assign pool = g_pick[gk-1].pool & ~g_pick[gk-1].win;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [DEPTH-1:0] beats;
      for (genvar gj = 0; gj < DEPTH; gj++) begin : g_cmp
        if (gj == gi) begin : g_self
          assign beats[gj] = 1'b1;
        end else begin : g_other
          // Age breaks ties; the age matrix is a strict order over valid entries.
          assign beats[gj] = ~pool[gj] | (key[gi] > key[gj]) |
                             ((key[gi] == key[gj]) & older[gi][gj]);
        end
      end
      assign win[gi] = pool[gi] & (&beats);
    end

    assign grant[gk]       = win;
    assign grant_valid[gk] = |pool;
  end

endmodule

// File: rtl/rs_multi_dispatch.sv
// Reservation station: buffers task packets and issues up to NUM_PE per
// cycle, ranked by {starved, iteration match, age}.
module rs_multi_dispatch
  import rs_pkg::*;
#(
  parameter int DEPTH      = RS_DEPTH,
  parameter int NUM_PE     = RS_NUM_PE,
  parameter int PKT_W      = RS_PKT_W,
  parameter int ITER_W     = RS_ITER_W,
  parameter int ITER_LSB   = RS_ITER_LSB,
  parameter int STARVE_LIM = RS_STARVE_LIM,
  localparam int RI_W      = $clog2(ITER_W),
  localparam int OCC_W     = $clog2(DEPTH + 1),
  localparam int RANK_W    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [PKT_W-1:0]        in_packet,
  output logic                    in_ready,
  input  logic [RI_W-1:0]         replay_iter,
  input  logic [NUM_PE-1:0]       pe_idle,
  input  logic                    flush,
  output logic [NUM_PE-1:0]       out_valid,
  output logic [NUM_PE*PKT_W-1:0] out_packet,
  output logic [OCC_W-1:0]        occupancy,
  output logic                    rs_empty,
  output logic                    rs_full
);

  rs_entry_t                   entry_reg [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] age_reg;   // age_reg[i][j]: entry i is older than j
  logic [OCC_W-1:0]            occupancy_reg;

  logic [DEPTH-1:0]             valid_vec;
  logic [DEPTH-1:0][1:0]        key;
  logic [NUM_PE-1:0][DEPTH-1:0] grant;
  logic [NUM_PE-1:0]            grant_valid;
  logic [DEPTH-1:0]             issue_mask;
  logic [OCC_W-1:0]             issue_cnt;
  logic [OCC_W-1:0]             occupancy_next;
  logic [DEPTH-1:0]             alloc_vec;
  logic [RANK_W-1:0]            rank;
  logic                         do_accept;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_key
    logic [ITER_W-1:0] mask;
    assign mask           = entry_reg[gi].packet[ITER_LSB +: ITER_W];
    assign valid_vec[gi]  = entry_reg[gi].valid;
    assign key[gi]        = {entry_reg[gi].wait_cnt == RS_WAIT_W'(STARVE_LIM),
                             (int'(replay_iter) < ITER_W) && mask[replay_iter]};
  end

  rs_rank_select #(
    .DEPTH  (DEPTH),
    .NUM_PE (NUM_PE)
  ) u_rank (
    .cand        (valid_vec),
    .key         (key),
    .older       (age_reg),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // The k-th idle PE (ascending index) takes the k-th ranked grant.
  always_comb begin
    out_valid  = '0;
    out_packet = '0;
    issue_mask = '0;
    rank       = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      if (pe_idle[p]) begin
        if (grant_valid[rank] && !flush) begin
          out_valid[p] = 1'b1;
          issue_mask   = issue_mask | grant[rank];
          for (int e = 0; e < DEPTH; e++) begin
            if (grant[rank][e]) out_packet[p*PKT_W +: PKT_W] = entry_reg[e].packet;
          end
        end
        rank = rank + RANK_W'(1);
      end
    end
  end

  always_comb begin
    issue_cnt = '0;
    for (int e = 0; e < DEPTH; e++) issue_cnt = issue_cnt + OCC_W'(issue_mask[e]);
  end

  // Lowest free slot in the pre-issue view; slots freed this cycle wait a cycle.
  assign alloc_vec      = ~valid_vec & (valid_vec + DEPTH'(1));
  assign rs_full        = (occupancy_reg == OCC_W'(DEPTH));
  assign rs_empty       = (occupancy_reg == '0);
  assign occupancy      = occupancy_reg;
  assign in_ready       = ~rs_full & ~flush;
  assign do_accept      = in_valid & in_ready;
  assign occupancy_next = occupancy_reg + OCC_W'(do_accept) - issue_cnt;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int e = 0; e < DEPTH; e++) entry_reg[e] <= '0;
      age_reg       <= '0;
      occupancy_reg <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (do_accept && alloc_vec[e]) begin
          entry_reg[e] <= '{valid: 1'b1, packet: in_packet, wait_cnt: '0};
        end else if (issue_mask[e]) begin
          entry_reg[e] <= '0;
        end else if (entry_reg[e].valid && entry_reg[e].wait_cnt != RS_WAIT_W'(STARVE_LIM)) begin
          entry_reg[e].wait_cnt <= entry_reg[e].wait_cnt + RS_WAIT_W'(1);
        end
      end
      // A new entry is younger than everything else.
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (do_accept && alloc_vec[i]) age_reg[i][j] <= 1'b0;
          else if (do_accept && alloc_vec[j] && i != j) age_reg[i][j] <= 1'b1;
        end
      end
      occupancy_reg <= occupancy_next;
    end
  end

  a_out_subset_idle: assert property (@(posedge clk) disable iff (reset)
    (out_valid & ~pe_idle) == '0);
  a_no_double_issue: assert property (@(posedge clk) disable iff (reset)
    int'(issue_cnt) == $countones(out_valid));
  a_issue_bound: assert property (@(posedge clk) disable iff (reset)
    int'(issue_cnt) <= (($countones(pe_idle) < int'(occupancy_reg)) ?
                        $countones(pe_idle) : int'(occupancy_reg)));

endmodule
